// File: rtl/mul_sequencer_if.sv
// Execute-stage handshake between the pipeline control and the iterative multiply sequencer.
// The master side is the pipeline (drives operands/start); the slave side is the sequencer.
interface mul_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             MulStartE;
    logic             AccumE;
    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] SrcBE;
    logic [WIDTH-1:0] SrcCE;
    logic             FlushE;
    logic             MulStallE;
    logic             MulDoneE;
    logic [WIDTH-1:0] MulResultE;
    logic [1:0]       MulFlagsE;

    modport master (
        output MulStartE,
        output AccumE,
        output SrcAE,
        output SrcBE,
        output SrcCE,
        output FlushE,
        input  MulStallE,
        input  MulDoneE,
        input  MulResultE,
        input  MulFlagsE
    );

    modport slave (
        input  MulStartE,
        input  AccumE,
        input  SrcAE,
        input  SrcBE,
        input  SrcCE,
        input  FlushE,
        output MulStallE,
        output MulDoneE,
        output MulResultE,
        output MulFlagsE
    );
endinterface

// File: rtl/mul_sequencer.sv
// Iterative shift-add MUL/MLA unit for the E stage: retires RADIX multiplier bits per cycle,
// stalls F/D/E while busy and presents the low WIDTH bits of the product (+accumulator) on done.
module mul_sequencer #(
    parameter int WIDTH = 32,
    parameter int RADIX = 1
) (
    input  logic            clk,
    input  logic            reset,
    mul_sequencer_if.slave  bus
);

    localparam int ITER  = WIDTH / RADIX;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

    state_e             state_q,  state_d;
    logic [WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_q,    acc_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [1:0]         flags_q,  flags_d;
    logic               done_q,   done_d;
    logic               stall_s;
    logic [WIDTH-1:0]   acc_step_s;
    logic               last_iter_s;

    // Product of one RADIX-bit multiplier digit with the (already shifted) multiplicand, mod 2^WIDTH.
    function automatic logic [WIDTH-1:0] digit_product(
        input logic [RADIX-1:0] digit,
        input logic [WIDTH-1:0] mc
    );
        logic [WIDTH-1:0] sum;
        sum = {WIDTH{1'b0}};
        for (int i = 0; i < RADIX; i++) begin
            if (digit[i]) begin
                sum = sum + (mc << i);
            end else begin
                sum = sum;
            end
        end
        return sum;
    endfunction

    // {N,Z} of a finished result; C and V are deliberately not produced.
    function automatic logic [1:0] nz_flags(input logic [WIDTH-1:0] v);
        return {v[WIDTH-1], (v == {WIDTH{1'b0}})};
    endfunction

    // Datapath step for the current BUSY cycle.
    always_comb begin
        acc_step_s  = acc_q + digit_product(mplier_q[RADIX-1:0], mcand_q);
        last_iter_s = (cnt_q == CNT_W'(ITER - 1));
    end

    // Next-state, operand capture and stall generation.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        stall_s  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.MulStartE && !bus.FlushE) begin
                    mcand_d  = bus.SrcAE;
                    mplier_d = bus.SrcBE;
                    acc_d    = bus.AccumE ? bus.SrcCE : {WIDTH{1'b0}};
                    cnt_d    = {CNT_W{1'b0}};
                    stall_s  = 1'b1;
                    state_d  = S_BUSY;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_BUSY: begin
                stall_s = 1'b1;
                if (bus.FlushE) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d    = acc_step_s;
                    mcand_d  = mcand_q << RADIX;
                    mplier_d = mplier_q >> RADIX;
                    cnt_d    = cnt_q + CNT_W'(1);
                    // Result and flags are registered on the final step so they are stable in DONE.
                    if (last_iter_s) begin
                        result_d = acc_step_s;
                        flags_d  = nz_flags(acc_step_s);
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_BUSY;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mcand_q  <= {WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {WIDTH{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            result_q <= {WIDTH{1'b0}};
            flags_q  <= 2'b00;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
        end
    end

    // Stall must react in the start cycle itself, so it stays combinational on state/start/flush only.
    assign bus.MulStallE  = stall_s;
    assign bus.MulDoneE   = done_q;
    assign bus.MulResultE = result_q;
    assign bus.MulFlagsE  = flags_q;

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Iterative shift-add multiply controller serving the execute stage of the pipelined ARM core. It handles MUL and MLA (MulOpE).
- While the multiply is in flight, it holds the instruction in E and stalls the earlier stages.
- When finished, it returns the low WIDTH bits of the product (plus accumulator) for the E-stage result path.
- Replaces the single-cycle multiply in the ALU with a multi-cycle scheduled unit.

Parameters:
WIDTH, 32, operand/result width
RADIX, 1, multiplier bits retired per cycle; WIDTH must be a multiple of RADIX; legal values 1, 2, 4
ITER, WIDTH/RADIX, derived iteration count (localparam, not overridable)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
MulStartE  in  1  E-stage instruction is a valid multiply (MulOpE & condition passed)
AccumE  in  1  1 = MLA (add SrcCE), 0 = MUL
SrcAE  in  WIDTH  multiplicand (forwarded Rm path)
SrcBE  in  WIDTH  multiplier (forwarded Rs path)
SrcCE  in  WIDTH  accumulate operand (forwarded Ra path)
FlushE  in  1  kill E-stage instruction (branch/exception)
MulStallE  out  1  hold F/D/E stages and bubble M
MulDoneE  out  1  result valid this cycle; instruction advances at the clock edge ending this cycle
MulResultE  out  WIDTH  product result, valid when MulDoneE=1
MulFlagsE  out  2  {N,Z} of MulResultE, valid when MulDoneE=1

Behaviour:
- States: IDLE, BUSY, DONE (2-bit encoded). Reset value is IDLE.
- Reset values: all state, counter, accumulator, multiplicand and multiplier registers = 0; MulStallE = 0; MulDoneE = 0; MulResultE = 0; MulFlagsE = 0.
- IDLE:
  - If MulStartE=1 and FlushE=0: capture mcand=SrcAE and mplier=SrcBE; set acc = AccumE ? SrcCE : 0; set cnt = 0; go to BUSY.
  - MulStallE is asserted combinationally in this same cycle, so the instruction is held in E.
  - If FlushE=1: no capture, stay in IDLE, MulStallE=0.
- BUSY, each cycle:
  - acc += (mplier[RADIX-1:0] * mcand), truncated to WIDTH.
  - mcand <<= RADIX; mplier >>= RADIX (logical shift); cnt++.
  - When cnt == ITER-1 (the update in that cycle is the last one), go to DONE.
  - MulStallE=1 for the whole state.
- DONE:
  - MulStallE=0 and MulDoneE=1.
  - MulResultE = acc.
  - MulFlagsE: N = acc[WIDTH-1]; Z = (acc == 0).
  - Go to IDLE unconditionally. MulStartE is not sampled in DONE; it still reflects the finishing instruction.
- Outside DONE: MulResultE and MulFlagsE hold their last DONE values and MulDoneE=0.
- Latency: start in cycle T gives BUSY in cycles T+1..T+ITER and DONE in cycle T+ITER+1. MulStallE is high for ITER+1 cycles (T..T+ITER).
- Back-to-back multiplies: the following multiply enters E in the cycle after DONE, is seen as a start in IDLE, and has no dead cycle beyond that IDLE start cycle.
- Flush:
  - FlushE=1 in BUSY: abort to IDLE at the next edge; MulDoneE is never raised; MulStallE drops in the cycle after the flush.
  - FlushE=1 in DONE: MulDoneE is still asserted, and the consumer gates writeback.
- Reset in any state: IDLE at the next edge; all outputs return to their reset values.
- Arithmetic:
  - Unsigned modulo 2^WIDTH. Low-WIDTH bits are identical for signed operands.
  - No carry or overflow flags are produced; C and V are left unchanged by the consumer.
- Operand capture happens only in the IDLE start cycle; input changes during BUSY are ignored.
- MulStallE must have no combinational path from MulResultE; it depends only on state, MulStartE and FlushE.

Test Plan:
- MUL: SrcAE=3, SrcBE=5, AccumE=0, one-cycle start (held while stalled) -> MulStallE high for 33 cycles; MulDoneE pulses once at cycle 33 after start; MulResultE=15; MulFlagsE=2'b00.
- MLA wrap: SrcAE=0xFFFFFFFF, SrcBE=2, SrcCE=1, AccumE=1 -> MulResultE=0xFFFFFFFF; N=1, Z=0.
- Zero: SrcAE=0x12345678, SrcBE=0, AccumE=0 -> MulResultE=0; Z=1; latency unchanged at 33 cycles.
- Back-to-back: 7*6, then 0x10000*0x10000 started the cycle after DONE -> results 42, then 0x00000000 (Z=1). The second DONE comes exactly 34 cycles after the first.
- Flush: start 9*9, assert FlushE at BUSY cycle 10 -> no MulDoneE; MulStallE low the next cycle; state IDLE. A following 2*2 start completes with result 4.
- Reset mid-op plus RADIX=4 build: reset at BUSY cycle 5 -> all outputs 0 on the next cycle. With RADIX=4, 0xFFFF*0xFFFF = 0xFFFE0001, done 9 cycles after start.
